// File: rtl/axil_master_single_if.sv
// axil_master_single_if: command/response stream plus AXI4-Lite master channels of axil_master_single.
interface axil_master_single_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_we;
  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [DATA_WIDTH-1:0]   cmd_wdata;
  logic [DATA_WIDTH/8-1:0] cmd_wstrb;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic                    rsp_we;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic [1:0]              rsp_resp;
  logic [ADDR_WIDTH-1:0]   m_axil_awaddr;
  logic [2:0]              m_axil_awprot;
  logic                    m_axil_awvalid;
  logic                    m_axil_awready;
  logic [DATA_WIDTH-1:0]   m_axil_wdata;
  logic [DATA_WIDTH/8-1:0] m_axil_wstrb;
  logic                    m_axil_wvalid;
  logic                    m_axil_wready;
  logic [1:0]              m_axil_bresp;
  logic                    m_axil_bvalid;
  logic                    m_axil_bready;
  logic [ADDR_WIDTH-1:0]   m_axil_araddr;
  logic [2:0]              m_axil_arprot;
  logic                    m_axil_arvalid;
  logic                    m_axil_arready;
  logic [DATA_WIDTH-1:0]   m_axil_rdata;
  logic [1:0]              m_axil_rresp;
  logic                    m_axil_rvalid;
  logic                    m_axil_rready;
  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    output cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    output m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    output m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
    output m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready
  );
  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output m_axil_awready, m_axil_wready, m_axil_bresp, m_axil_bvalid,
    output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
    input  cmd_ready, rsp_valid, rsp_we, rsp_rdata, rsp_resp,
    input  m_axil_awaddr, m_axil_awprot, m_axil_awvalid,
    input  m_axil_wdata, m_axil_wstrb, m_axil_wvalid, m_axil_bready,
    input  m_axil_araddr, m_axil_arprot, m_axil_arvalid, m_axil_rready
  );
endinterface

// File: rtl/axil_master_single.sv
// axil_master_single: single-outstanding AXI4-Lite initiator turning commands into read/write transactions.
module axil_master_single #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12
) (
  input logic                   axi_clock,
  input logic                   rst_n,
  axil_master_single_if.master  bus
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
  state_t                  state_q;
  logic                    cmd_ready_q, we_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rsp_rdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    rsp_valid_q, rsp_we_q;
  logic [1:0]              rsp_resp_q;
  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_we         = rsp_we_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_resp       = rsp_resp_q;
  assign bus.m_axil_awaddr  = addr_q;
  assign bus.m_axil_awprot  = 3'b000;
  assign bus.m_axil_awvalid = awvalid_q;
  assign bus.m_axil_wdata   = wdata_q;
  assign bus.m_axil_wstrb   = wstrb_q;
  assign bus.m_axil_wvalid  = wvalid_q;
  assign bus.m_axil_bready  = bready_q;
  assign bus.m_axil_araddr  = addr_q;
  assign bus.m_axil_arprot  = 3'b000;
  assign bus.m_axil_arvalid = arvalid_q;
  assign bus.m_axil_rready  = rready_q;
  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            we_q        <= bus.cmd_we;
            addr_q      <= bus.cmd_addr;
            wdata_q     <= bus.cmd_wdata;
            wstrb_q     <= bus.cmd_wstrb;
            awvalid_q   <= bus.cmd_we;
            wvalid_q    <= bus.cmd_we;
            arvalid_q   <= !bus.cmd_we;
            state_q     <= bus.cmd_we ? WR_ADDR_DATA : RD_ADDR;
          end
        end
        // AW and W complete independently; a channel already done counts as ready
        WR_ADDR_DATA: begin
          if (bus.m_axil_awready) awvalid_q <= 1'b0;
          if (bus.m_axil_wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || bus.m_axil_awready) && (!wvalid_q || bus.m_axil_wready)) begin
            bready_q <= 1'b1;
            state_q  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.m_axil_bvalid) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bus.m_axil_bresp;
            state_q     <= RESP;
          end
        end
        RD_ADDR: begin
          if (bus.m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (bus.m_axil_rvalid) begin
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_we_q    <= we_q;
            rsp_rdata_q <= bus.m_axil_rdata;
            rsp_resp_q  <= bus.m_axil_rresp;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/axil_master_single.md
# axil_master_single

Single-outstanding AXI4-Lite initiator that turns a simple valid/ready command stream into AXI-Lite read or write transactions and returns one response per command. It is the master-side counterpart of the AXI-Lite BRAM responders. It lets FPGA-side logic (sequencers, config loaders, test drivers) read and write any AXI-Lite slave without hand-coding channel handshakes.

## Interface
Parameters:
- DATA_WIDTH, 32, AXI data width; must be 32 or 64.
- ADDR_WIDTH, 12, byte-address width of the AXI address channels.

Ports:
- axi_clock  in  1  the only clock; all logic is synchronous to it.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when `cmd_valid & cmd_ready`.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address, passed unmodified.
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads.
- cmd_wstrb  in  DATA_WIDTH/8  write strobes; ignored for reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when `rsp_valid & rsp_ready`.
- rsp_we  out  1  echo of `cmd_we` for this response.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as returned by the slave.
- m_axil_awaddr, awprot(3), awvalid out; awready in.
- m_axil_wdata, wstrb, wvalid out; wready in.
- m_axil_bresp(2), bvalid in; bready out.
- m_axil_araddr, arprot(3), arvalid out; arready in.
- m_axil_rdata, rresp(2), rvalid in; rready out.

## Operation
- States: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - `cmd_ready` = 1, all AXI valids/readies = 0.
  - On accept: register addr, wdata, wstrb and we.
  - Go to WR_ADDR_DATA if we = 1, else RD_ADDR.
- WR_ADDR_DATA:
  - `awvalid` and `wvalid` both rise on state entry.
  - Each one drops independently on the cycle after its own ready is sampled high with valid high. Handshakes complete in either order, or in the same cycle.
  - Once both handshakes are done, go to WR_RESP.
  - A valid never drops before its handshake.
  - Address and data stay stable while valid is high.
- WR_RESP:
  - `bready` = 1.
  - On `bvalid`: capture bresp into `rsp_resp`, set `rsp_rdata` = 0, go to RESP.
- RD_ADDR:
  - `arvalid` = 1 until `arready` is sampled high, then go to RD_DATA.
- RD_DATA:
  - `rready` = 1.
  - On `rvalid`: capture rdata and rresp, go to RESP.
- RESP:
  - `rsp_valid` = 1; outputs held stable until `rsp_ready`, then return to IDLE.
- `awprot` and `arprot` are fixed at 3'b000.
- `rsp_resp` is forwarded verbatim; this block never generates errors.
- Exactly one transaction is outstanding at a time; there is no ordering ambiguity.
- No timeout: a slave that never responds stalls the block until reset.

## Timing
- Reset (async assert, sync release): state = IDLE. Every output is 0 except `cmd_ready`, which becomes 1 on the first clock after release.
- Accept edge = cycle 0. AW/W/AR valid are high from cycle 1 (registered outputs; no combinational path from cmd to AXI).
- `bready` and `rready` rise the cycle after the last address/data handshake.
- `rsp_valid` rises the cycle after the B or R handshake.
- `cmd_ready` is 0 from cycle 1 through the `rsp_ready` handshake cycle inclusive. It is 1 again the cycle after that handshake, so back-to-back commands are accepted every N+1 cycles.
- With all slave readies constantly high:
  - Write: AW/W handshake at cycle 1, B at cycle 2, `rsp_valid` at cycle 3.
  - Read: AR at cycle 1, R at cycle 2, `rsp_valid` at cycle 3.
- Reset mid-transaction: all valids and readies drop immediately (asynchronously) and the response is discarded. Recovering the slave is system-level responsibility.

## Test plan
- Write, all readies high: cmd addr 0x010, data 0xDEADBEEF, strb 0xF -> AW/W handshake at cycle 1, `bready` at cycle 2, `rsp_valid` at cycle 3 with rsp_we = 1, resp = 0, rdata = 0.
- Skewed write: `wready` high immediately, `awready` delayed 3 cycles -> `wvalid` drops after cycle 1; `awvalid` is held high with stable addr until cycle 4; B is awaited only after both handshakes; a single response is produced.
- Read with latency: araddr 0x024, slave returns rdata 0x12345678 with `rvalid` 5 cycles after AR -> `rsp_rdata` = 0x12345678, resp = 0; `rready` stays high throughout the wait.
- Error pass-through: slave returns bresp = 2'b10 on a write and rresp = 2'b11 on a read -> `rsp_resp` = 2'b10 and 2'b11 respectively.
- Response back-pressure: `rsp_ready` low for 4 cycles -> `rsp_*` stable, `cmd_ready` = 0, no new AXI activity; the next command is accepted the cycle after `rsp_ready`.
- Reset mid-read: assert `rst_n` low while `arvalid` = 1 -> `arvalid` drops in the same cycle and no `rsp_valid` appears; after release, `cmd_ready` = 1 and a fresh write completes normally.
